// File: rtl/mix_columns_seq.sv
// Sequential masked AES MixColumns / InvMixColumns engine.
// Inverse runs as a P pre-multiply pass followed by the forward pass (InvMC = MC*P).
module mix_columns_seq #(
    parameter int d   = 2,
    parameter int CPC = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         inv,
    input  logic [3:0][3:0][d:0][7:0]    in_state,
    input  logic [16*CPC-1:0][7:0]       random_vect,
    output logic                         rnd_req,
    input  logic [d:0][7:0]              L,
    input  logic [d:0][7:0]              B_ext_MC,
    input  logic [d:0][7:0]              MC,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0][3:0][d:0][7:0]    out_state
);

    typedef logic [7:0]        red_poly_t;
    typedef red_poly_t [d:0]   cw_t;
    typedef cw_t [3:0]         col_t;
    typedef col_t [3:0]        state_t;
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_MIX, S_DONE} fsm_e;

    localparam logic [1:0] STEP     = 2'(CPC);
    localparam logic [1:0] LAST_PTR = 2'(4 - CPC);

    if (!(CPC == 1 || CPC == 2 || CPC == 4)) begin : g_bad_cpc
        $error("mix_columns_seq: CPC must be 1, 2 or 4");
    end

    function automatic red_poly_t xtime(red_poly_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic red_poly_t gf_mul(red_poly_t a, red_poly_t b);
        red_poly_t p;
        red_poly_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Share-wise doubling, refreshed by r times a zero-decoding codeword.
    function automatic cw_t mul_L2(cw_t x, red_poly_t r, cw_t bm);
        cw_t y;
        for (int s = 0; s <= d; s++) y[s] = xtime(x[s]) ^ gf_mul(r, bm[s]);
        return y;
    endfunction

    function automatic cw_t mul_add_p(cw_t x, red_poly_t r, cw_t m);
        cw_t y;
        for (int s = 0; s <= d; s++) y[s] = x[s] ^ gf_mul(r, m[s]);
        return y;
    endfunction

    // P = circ{5,0,4,0}; each 4*x is two chained doublings with its own randoms.
    function automatic col_t pre_col(col_t x, logic [15:0][7:0] r, cw_t bm);
        col_t y;
        for (int i = 0; i < 4; i++) begin
            y[i] = mul_L2(mul_L2(x[i], r[4*i], bm), r[4*i+1], bm) ^ x[i]
                 ^ mul_L2(mul_L2(x[(i+2)%4], r[4*i+2], bm), r[4*i+3], bm);
        end
        return y;
    endfunction

    function automatic col_t mix_col(col_t x, logic [15:0][7:0] r, cw_t bm, cw_t m);
        col_t y;
        cw_t  acc;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                case ((j - i + 4) % 4)
                    0:       acc = acc ^ mul_L2(x[j], r[4*i+j], bm);
                    1:       acc = acc ^ mul_L2(x[j], r[4*i+j], bm) ^ x[j];
                    default: acc = acc ^ mul_add_p(x[j], r[4*i+j], m);
                endcase
            end
            y[i] = acc;
        end
        return y;
    endfunction

    fsm_e                  r_fsm;
    logic [1:0]            r_col_ptr;
    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_rnd_req;
    logic [CPC-1:0][1:0]   w_idx;
    col_t [CPC-1:0]        w_new;
    logic                  w_last;
    logic                  w_unused_l;

    // L only matters to whoever decodes the shares.
    assign w_unused_l = ^L;
    assign w_last     = (r_col_ptr == LAST_PTR);

    for (genvar gi = 0; gi < CPC; gi++) begin : g_col
        assign w_idx[gi] = r_col_ptr + 2'(gi);
        assign w_new[gi] = (r_fsm == S_PRE)
            ? pre_col(r_state[w_idx[gi]], random_vect[16*gi +: 16], B_ext_MC)
            : mix_col(r_state[w_idx[gi]], random_vect[16*gi +: 16], B_ext_MC, MC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_col_ptr   <= '0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_rnd_req   <= 1'b0;
        end else begin
            if (r_fsm == S_PRE || r_fsm == S_MIX) begin
                for (int g = 0; g < CPC; g++) r_state[w_idx[g]] <= w_new[g];
            end
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state    <= in_state;
                        r_col_ptr  <= '0;
                        r_fsm      <= inv ? S_PRE : S_MIX;
                        r_in_ready <= 1'b0;
                        r_rnd_req  <= 1'b1;
                    end
                end
                S_PRE: begin
                    if (w_last) begin
                        r_col_ptr <= '0;
                        r_fsm     <= S_MIX;
                    end else begin
                        r_col_ptr <= r_col_ptr + STEP;
                    end
                end
                S_MIX: begin
                    if (w_last) begin
                        r_col_ptr   <= '0;
                        r_fsm       <= S_DONE;
                        r_rnd_req   <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_col_ptr <= r_col_ptr + STEP;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_fsm       <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign rnd_req   = r_rnd_req;
    assign out_state = r_state;

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential, parametrised CLM MixColumns engine for a full 4x4 masked AES state, supporting forward and inverse modes. The engine holds one state in an internal register and processes CPC columns per cycle, refreshing randomness on every partial product. Inverse mode runs as a pre-multiply pass by the P matrix followed by a forward MixColumns pass, using InvMC = MC·P. It sits between ShiftRows and AddRoundKey in the round datapath and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- d, codebase default d, masking order, passed to all codeword types.
- CPC, 1, columns processed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_state and inv are valid.
- in_ready  output  1  engine can accept a state; high only in IDLE.
- inv  input  1  1 selects InvMixColumns. Sampled only on the accept edge.
- in_state  input  state_vec_t  four columns of four masked bytes.
- random_vect  input  red_poly_t[0:16*CPC-1]  fresh randomness, 16 elements per processed column.
- rnd_req  output  1  random_vect is consumed at this cycle's edge.
- L, B_ext_MC, MC  input  mm_matrix_t, bm_matrix_t, mr_matrix_t  masking matrices. Must stay static while the engine is busy.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  state_vec_t  result register.

## Operation
- States are IDLE, PRE, MIX and DONE. N = 4/CPC is the number of passes per state.
- IDLE:
  - in_ready=1.
  - On in_valid, load in_state into the state register, latch inv, and clear col_ptr.
  - Next state is PRE if inv=1, otherwise MIX.
- PRE (inverse only):
  - Columns col_ptr..col_ptr+CPC-1 are replaced by P·column, with P = {5,0,4,0; 0,5,0,4; 4,0,5,0; 0,4,0,5}.
  - 4·x = mul_L2(mul_L2(x, r_a), r_b).
  - 5·x = 4·x ^ x.
  - Zero coefficients contribute '0.
  - Each column consumes 16 randoms: 8 nonzero entries × 2.
  - col_ptr advances by CPC. After N cycles, col_ptr is cleared and the state moves to MIX.
- MIX:
  - Columns are replaced by MC·column using the AES {2,3,1,1} circulant.
  - Coefficient 1 uses mul_add_p with matrix MC.
  - Coefficient 2 uses mul_L2.
  - Coefficient 3 uses mul_L2 ^ x.
  - Each column consumes 16 randoms, one per element.
  - After N cycles, the state moves to DONE.
- rnd_req=1 exactly in PRE and MIX. Column k of the current group uses random_vect[16k +: 16].
- DONE:
  - out_valid=1 and out_state equals the state register.
  - On out_ready, the next state is IDLE.
- Correctness: the decoded out_state equals AES MixColumns, or InvMixColumns when inv=1, of the decoded in_state, for any randomness.
- in_valid outside IDLE is ignored. A change to inv after acceptance has no effect.

## Timing
- Reset values: state=IDLE, col_ptr=0, state register='0. This gives in_ready=1, out_valid=0, rnd_req=0 and out_state='0.
- Latency:
  - Accept edge E0.
  - Forward mode: out_valid rises after edge E_N.
  - Inverse mode: out_valid rises after edge E_2N.
- Results are single-buffered:
  - out_state and out_valid stay stable while out_ready=0.
  - The handshake edge returns the engine to IDLE, and in_ready is 1 in the following cycle.
  - Minimum period per state is N+2 cycles forward and 2N+2 cycles inverse.
- Reset asserted at any point aborts the operation within the same cycle. The partial state is discarded and no out_valid is produced.
- out_ready held high before DONE means DONE lasts exactly one cycle.
- col_ptr wraps modulo 4 and is explicitly cleared at each phase change.

## Test plan
- Reset during MIX:
  - Stimulus: CPC=1, assert rst two cycles after accept.
  - Required: in_ready=1, out_valid=0 and rnd_req=0 immediately. No output appears; the next accepted state completes normally.
- Forward, CPC=1:
  - Stimulus: columns db135345, f20a225c, 01010101, c6c6c6c6.
  - Required: decoded 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6. out_valid after 4 edges; rnd_req high exactly 4 cycles.
- Inverse, CPC=2:
  - Stimulus: the expected forward outputs above.
  - Required: decoded originals restored. out_valid after 4 edges; rnd_req high 4 cycles.
- Forward, CPC=4:
  - Stimulus: column d4bf5d30 replicated in all four columns.
  - Required: decoded 046681e5 in all columns. out_valid after 1 edge.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid.
  - Required: out_state stable, in_ready=0, pulses ignored. The single handshake returns the engine to IDLE.
- Mask refresh:
  - Stimulus: the same decoded state twice, with different random streams.
  - Required: identical decoded outputs and differing encoded out_state.
